// File: rtl/osd_udec_reader_seq.sv
// Sequential unsigned-decimal parser: fetches characters from OSD character RAM,
// skips leading spaces, accumulates ASCII digits and saturates on overflow.
module osd_udec_reader_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [15:0]      base_addr,
  input  logic [7:0]       max_len,
  output logic             char_re,
  output logic [15:0]      char_addr,
  input  logic [7:0]       char_rdata,
  output logic [WIDTH-1:0] value,
  output logic [7:0]       ndigits,
  output logic             overflow,
  output logic             error,
  output logic [1:0]       dbg_state
);

  localparam int XW = WIDTH + 4;
  localparam logic [XW-1:0] TEN = XW'(10);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      base_q, base_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       pos_q, pos_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             char_re_q, char_re_d;
  logic [15:0]      char_addr_q, char_addr_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [7:0]       ndigits_q, ndigits_d;
  logic             overflow_q, overflow_d;
  logic             error_q, error_d;

  // Character classification of the RAM data sampled in S_CHECK.
  logic          is_digit;
  logic          is_space;
  logic          terminate;
  logic [3:0]    digit;
  logic [XW-1:0] acc_ext;
  logic [XW-1:0] mac;
  logic [7:0]    pos_inc;
  logic          res_err;

  always_comb begin
    is_digit  = (char_rdata >= 8'h30) && (char_rdata <= 8'h39);
    is_space  = (char_rdata == 8'h20);
    terminate = !is_digit && !(is_space && !seen_q);
    digit     = char_rdata[3:0];
    acc_ext   = {4'b0000, acc_q};
    mac       = (acc_ext * TEN) + XW'(digit);
    pos_inc   = pos_q + 8'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (max_len == 8'd0) ? S_DONE : S_READ;
        end
      end
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (terminate || (pos_inc == len_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Parse datapath: accumulator, counters and flags.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    pos_d  = pos_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = max_len;
          pos_d  = 8'd0;
          acc_d  = '0;
          cnt_d  = 8'd0;
          seen_d = 1'b0;
          ovf_d  = 1'b0;
          err_d  = 1'b0;
        end
      end
      S_CHECK: begin
        pos_d = pos_inc;
        if (is_digit) begin
          // Once saturated, stay saturated even if later digits would fit.
          if ((mac[XW-1:WIDTH] != 4'd0) || ovf_q) begin
            ovf_d = 1'b1;
            acc_d = '1;
          end else begin
            acc_d = mac[WIDTH-1:0];
          end
          cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          seen_d = 1'b1;
        end else if (terminate && !seen_q) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      pos_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      pos_q  <= pos_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  // Output logic: decoded from the next state so every output is a flop.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    char_re_d   = (state_d == S_READ);
    char_addr_d = char_addr_q;
    value_d     = value_q;
    ndigits_d   = ndigits_q;
    overflow_d  = overflow_q;
    error_d     = error_q;
    res_err     = err_d | ~seen_d;
    if (state_d == S_READ) begin
      char_addr_d = base_d + {8'd0, pos_d};
    end
    // An error result hides any partial value and overflow.
    if (state_d == S_DONE) begin
      value_d    = res_err ? '0 : acc_d;
      ndigits_d  = res_err ? 8'd0 : cnt_d;
      overflow_d = res_err ? 1'b0 : ovf_d;
      error_d    = res_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      char_re_q   <= 1'b0;
      char_addr_q <= '0;
      value_q     <= '0;
      ndigits_q   <= '0;
      overflow_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      char_re_q   <= char_re_d;
      char_addr_q <= char_addr_d;
      value_q     <= value_d;
      ndigits_q   <= ndigits_d;
      overflow_q  <= overflow_d;
      error_q     <= error_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign char_re   = char_re_q;
  assign char_addr = char_addr_q;
  assign value     = value_q;
  assign ndigits   = ndigits_q;
  assign overflow  = overflow_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_osd_udec_reader_seq.sv
// Self-checking bench for osd_udec_reader_seq: RAM model, directed and random
// strings, compared against a string-level decimal parse model.
module tb_osd_udec_reader_seq;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [15:0]      base_addr;
  logic [7:0]       max_len;
  logic             char_re;
  logic [15:0]      char_addr;
  logic [7:0]       char_rdata;
  logic [WIDTH-1:0] value;
  logic [7:0]       ndigits;
  logic             overflow;
  logic             error;
  logic [1:0]       dbg_state;

  osd_udec_reader_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .base_addr  (base_addr),
    .max_len    (max_len),
    .char_re    (char_re),
    .char_addr  (char_addr),
    .char_rdata (char_rdata),
    .value      (value),
    .ndigits    (ndigits),
    .overflow   (overflow),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q  [$];
  logic [15:0] exp_q [$];

  logic [63:0] exp_val;
  int          exp_nd;
  bit          exp_ovf;
  bit          exp_err;
  int          exp_n;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Character RAM: data appears one cycle after the read strobe; garbage otherwise.
  initial begin
    logic        re_s;
    logic [15:0] addr_s;
    char_rdata = 8'h00;
    forever begin
      @(posedge clk);
      re_s   = char_re;
      addr_s = char_addr;
      #1;
      if (re_s) begin
        char_rdata = mem[addr_s];
        rd_q.push_back(addr_s);
      end else begin
        char_rdata = 8'($urandom);
      end
    end
  end

  task automatic put_str(input logic [15:0] base, input string s);
    logic [15:0] a;
    for (int i = 0; i < s.len(); i++) begin
      a = base + 16'(i);
      mem[a] = s[i];
    end
  endtask

  // Reference: walk the string as a human would read a number off screen.
  task automatic model(input logic [15:0] base, input logic [7:0] len);
    logic [63:0] acc;
    logic [63:0] nxt;
    logic [15:0] a;
    logic [7:0]  c;
    bit          seen;
    acc = 0; exp_nd = 0; exp_ovf = 0; exp_err = 0; exp_n = 0; seen = 0;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      a = base + 16'(i);
      exp_q.push_back(a);
      exp_n++;
      c = mem[a];
      if (c >= "0" && c <= "9") begin
        nxt = acc * 10 + 64'(c - 8'h30);
        if (exp_ovf || nxt > 64'hFFFF_FFFF) begin
          exp_ovf = 1;
          acc = 64'hFFFF_FFFF;
        end else begin
          acc = nxt;
        end
        if (exp_nd < 255) exp_nd++;
        seen = 1;
      end else if (c == " " && !seen) begin
        continue;
      end else begin
        if (!seen) exp_err = 1;
        break;
      end
    end
    if (!seen) exp_err = 1;
    if (exp_err) begin
      exp_val = 0; exp_nd = 0; exp_ovf = 0;
    end else begin
      exp_val = acc;
    end
  endtask

  task automatic run_parse(input logic [15:0] base, input logic [7:0] len,
                           input bit poke_busy, input bit poke_done);
    int cyc;
    bit busy_ok;
    model(base, len);
    rd_q.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; max_len = len;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 16'($urandom); max_len = 8'($urandom);
    cyc = 1; busy_ok = 1;
    while (!done && cyc < 1000) begin
      if (!busy) busy_ok = 0;
      start = poke_busy && (cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = poke_done;
    check_eq("done_seen", done, 1);
    check_eq("done_cycle", cyc, 2 * exp_n + 1);
    check_eq("busy_during", busy_ok, 1);
    check_eq("busy_at_done", busy, 1);
    check_eq("value", value, exp_val);
    check_eq("ndigits", ndigits, exp_nd);
    check_eq("overflow", overflow, exp_ovf);
    check_eq("error", error, exp_err);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after", busy, 0);
    check_eq("done_pulse", done, 0);
    check_eq("value_hold", value, exp_val);
    @(posedge clk); #1;
    check_eq("idle_after_done_start", busy, 0);
    check_eq("read_count", rd_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rd_q.size()) check_eq("read_addr", rd_q[i], exp_q[i]);
    end
  endtask

  function automatic byte rand_char();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return byte'(8'h30 + 8'($urandom_range(0, 9)));
    if (r <= 7) return " ";
    if (r == 8) return "|";
    return "A";
  endfunction

  task automatic reset_test();
    int n_before;
    put_str(16'h0500, "98765");
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0500; max_len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_re", char_re, 0);
    check_eq("rst_addr", char_addr, 0);
    check_eq("rst_value", value, 0);
    check_eq("rst_ndigits", ndigits, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_err", error, 0);
    n_before = rd_q.size();
    repeat (3) begin @(posedge clk); #1; end
    check_eq("rst_no_reads", rd_q.size(), n_before);
    check_eq("rst_busy_held", busy, 0);
    rst_n = 1'b1;
    run_parse(16'h0500, 8'd5, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b;
    logic [7:0]  l;
    logic [15:0] a;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; max_len = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h7C;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_re", char_re, 0);
    check_eq("reset_addr", char_addr, 0);
    check_eq("reset_value", value, 0);
    check_eq("reset_ndigits", ndigits, 0);
    check_eq("reset_ovf", overflow, 0);
    check_eq("reset_err", error, 0);
    rst_n = 1'b1;

    put_str(16'h0100, "  42|");
    run_parse(16'h0100, 8'd5, 0, 0);
    put_str(16'h0200, "4294967295");
    run_parse(16'h0200, 8'd10, 0, 0);
    put_str(16'h0300, "4294967296");
    run_parse(16'h0300, 8'd10, 0, 0);
    put_str(16'h0400, "A12");
    run_parse(16'h0400, 8'd3, 0, 1);
    put_str(16'h0410, "   ");
    run_parse(16'h0410, 8'd3, 0, 0);
    run_parse(16'h0420, 8'd0, 0, 1);
    run_parse(16'h0100, 8'd5, 1, 0);
    put_str(16'hFFFE, "123|");
    run_parse(16'hFFFE, 8'd4, 1, 1);
    reset_test();

    for (int it = 0; it < 40; it++) begin
      b = 16'($urandom);
      if (it % 5 == 0) b = 16'hFFF8 + 16'($urandom_range(0, 7));
      l = 8'($urandom_range(0, 14));
      for (int i = 0; i <= int'(l); i++) begin
        a = b + 16'(i);
        if (it % 4 == 0) mem[a] = byte'(8'h30 + 8'($urandom_range(0, 9)));
        else mem[a] = rand_char();
      end
      run_parse(b, l, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osd_udec_reader_seq.md
# osd_udec_reader_seq

Sequential unsigned-decimal parser for the OSD character RAM. It is the read-side counterpart of the OSD decimal writer. On `start` it fetches up to `max_len` characters, one at a time, from character RAM beginning at `base_addr`. It skips leading spaces, accumulates ASCII digits into a binary value, and stops at the first non-digit. The debugger menu logic uses it to read back numeric fields that were typed or edited on screen.

## Interface
Parameters
- `WIDTH`, default 32: width of the parsed result in bits.

Ports
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin parse; sampled only in S_IDLE.
- `busy`  out  1: parse in progress.
- `done`  out  1: one-cycle pulse; results valid in this cycle.
- `base_addr`  in  16: address of the first character; latched on the accepted `start`.
- `max_len`  in  8: maximum number of characters to examine; latched on `start`.
- `char_re`  out  1: read strobe to character RAM, one cycle per character.
- `char_addr`  out  16: read address, valid while `char_re` = 1.
- `char_rdata`  in  8: RAM data, valid exactly one cycle after `char_re`.
- `value`  out  WIDTH: parsed result.
- `ndigits`  out  8: number of digit characters consumed.
- `overflow`  out  1: result exceeded 2^WIDTH−1 and was saturated.
- `error`  out  1: no digit found, or a non-space non-digit appeared before the first digit.

## Operation
- States: S_IDLE, S_READ, S_CHECK, S_DONE.
- **S_IDLE**
  - On `start`: latch `base_addr` and `max_len`; clear the accumulator, the digit counter, the position counter, the seen-digit flag and the overflow flag.
  - Go to S_DONE if `max_len` = 0, otherwise to S_READ.
- **S_READ**
  - Drive `char_re` = 1 and `char_addr` = `base_addr` + pos (16-bit add, wraps modulo 2^16).
  - Go to S_CHECK.
- **S_CHECK** samples `char_rdata` and classifies it:
  - **Digit (0x30–0x39):**
    - Compute `acc*10 + d` in WIDTH+4 bits.
    - If the high 4 bits are nonzero, or overflow is already set: set overflow and force the accumulator to all-ones.
    - Increment `ndigits` (saturates at 255) and set seen-digit.
  - **Space (0x20) with no digit seen yet:** skip it.
  - **Any other character, including a space after a digit:** terminates the field. Set error if no digit has been seen.
  - Increment pos.
  - Go to S_DONE on termination or when pos = `max_len`; otherwise go to S_READ.
- **S_DONE**
  - Pulse `done`.
  - Register the results:
    - `value` = accumulator, or 0 if error.
    - `ndigits` = digit count, or 0 if error.
    - `overflow` = overflow flag.
    - `error` = error flag OR no digit seen.
  - Go to S_IDLE.
- The terminating character is read but not counted in `ndigits`.
- Error takes priority: when `error` = 1, `value` = 0 and `overflow` = 0.

## Timing
- Reset values of all outputs are 0: `busy`, `done`, `char_re`, `char_addr`, `value`, `ndigits`, `overflow`, `error`. State resets to S_IDLE.
- All outputs are registered.
- Taking the `start` cycle as cycle 0:
  - Cycle 1: `busy` = 1, first `char_re`.
  - Character k: `char_re` in cycle 2k+1, data sampled in cycle 2k+2.
  - `done` falls in cycle 2N+1, where N is the number of characters read. N = 0 when `max_len` = 0, giving `done` in cycle 1.
- `busy` stays high from cycle 1 through the `done` cycle inclusive and is low in the cycle after.
- Results update only in the `done` cycle and hold until the next `done`.
- `start` while busy is ignored.
- `start` in the `done` cycle is ignored, because the block is in S_DONE.
- `start` in the cycle after `done` is accepted.
- Reset asserted mid-parse:
  - Immediate return to S_IDLE with all outputs 0.
  - No further `char_re`.
  - Any in-flight `char_rdata` is discarded.
- Address wrap: `base_addr` = 0xFFFF with pos 1 reads address 0x0000.

## Test plan
- RAM[0x0100..] = "  42|", `max_len` = 5
  - Reads 0x0100–0x0104 (5 reads; '|' is read and terminates).
  - `done` at cycle 11.
  - `value` = 42, `ndigits` = 2, `overflow` = 0, `error` = 0.
- "4294967295", `WIDTH` = 32, `max_len` = 10
  - `value` = 0xFFFFFFFF, `overflow` = 0, `ndigits` = 10, `done` at cycle 21.
- "4294967296" → `value` = 0xFFFFFFFF, `overflow` = 1, `error` = 0.
- "A12", `max_len` = 3 → a single read, `done` at cycle 3, `error` = 1, `value` = 0.
- "   ", `max_len` = 3 → `error` = 1, `ndigits` = 0.
- `max_len` = 0 → no `char_re`, `done` at cycle 1, `error` = 1.
- Pulse `start` again while busy → ignored.
- Assert `rst_n` low at cycle 4 of a parse → all outputs 0 next cycle; the following `start` parses normally.
